// File: rtl/rv_pkg.sv
// Shared RV32 core constants and types for the integer register file.
package rv_pkg;

    localparam int XLEN          = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bundle of the register file: read ports, two writeback ports, issue, flush.
// No handshakes: every port is sampled unconditionally every cycle, so there is no valid/ready pair.
interface reg_file_sb_if #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREGS = rv_pkg::NREGS_DEFAULT,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr0_en;
    logic [AW-1:0]       wr0_addr;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_addr;
    logic [XLEN-1:0]     wr1_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [AW:0]         pend_cnt;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, flush,
        input  rd_data, rd_busy, pend_cnt
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, flush,
        output rd_data, rd_busy, pend_cnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending bits with flush > (writeback clear, then issue set) priority and
// an incrementally maintained popcount.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic [NREGS-1:0] clr_vec,
    output logic [NREGS-1:0] pending,
    output logic [AW:0]      pend_cnt
);

    logic             iss_ok;
    logic [NREGS-1:0] set_vec;
    logic             inc;
    logic [AW:0]      dec;

    assign iss_ok = iss_en && (iss_addr != '0) && (int'(iss_addr) < NREGS);

    always_comb begin
        set_vec = '0;
        inc     = 1'b0;
        if (iss_ok) begin
            set_vec[iss_addr] = 1'b1;
            inc               = !pending[iss_addr];
        end
    end

    // Only bits that were pending and are not re-issued this cycle actually drop.
    always_comb begin
        dec = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (clr_vec[i] && pending[i] && !set_vec[i]) dec = dec + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else if (flush) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= (pending & ~clr_vec) | set_vec;
            pend_cnt <= pend_cnt + (AW+1)'(inc) - dec;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with write-to-read bypass and pending scoreboard.
// x0 reads as zero; writes and issues to x0 or out-of-range addresses are dropped.
module reg_file_sb
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2
) (
    input  logic         clock,
    input  logic         reset,
    reg_file_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] clr_vec;
    logic             wr0_ok;
    logic             wr1_ok;

    assign wr0_ok = bus.wr0_en && (bus.wr0_addr != '0) && (int'(bus.wr0_addr) < NREGS);
    assign wr1_ok = bus.wr1_en && (bus.wr1_addr != '0) && (int'(bus.wr1_addr) < NREGS);

    // wr0 is assigned last so it wins a same-address collision.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wr1_ok) regs[bus.wr1_addr] <= bus.wr1_data;
            if (wr0_ok) regs[bus.wr0_addr] <= bus.wr0_data;
        end
    end

    always_comb begin
        clr_vec = '0;
        if (wr0_ok) clr_vec[bus.wr0_addr] = 1'b1;
        if (wr1_ok) clr_vec[bus.wr1_addr] = 1'b1;
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clock    (clock),
        .reset    (reset),
        .flush    (bus.flush),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .clr_vec  (clr_vec),
        .pending  (pending),
        .pend_cnt (bus.pend_cnt)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            in_range;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr     = bus.rd_addr[p*AW +: AW];
        assign in_range = (addr != '0) && (int'(addr) < NREGS);

        // A same-cycle writeback both forwards its data and hides the pending bit it is clearing.
        always_comb begin
            data = '0;
            busy = 1'b0;
            if (in_range) begin
                if (wr0_ok && (bus.wr0_addr == addr)) begin
                    data = bus.wr0_data;
                end else if (wr1_ok && (bus.wr1_addr == addr)) begin
                    data = bus.wr1_data;
                end else begin
                    data = regs[addr];
                    busy = pending[addr];
                end
            end
        end

        assign bus.rd_data[p*XLEN +: XLEN] = data;
        assign bus.rd_busy[p]              = busy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, bypass, x0, collision, scoreboard, flush, async reset.
module tb_reg_file_sb;
    import rv_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;
    logic [XLEN-1:0] exp_q[$];

    reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.wr0_en   = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en   = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.iss_en   = 1'b0; bus.iss_addr = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic drv_wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.wr0_en = 1'b1; bus.wr0_addr = a; bus.wr0_data = d;
    endtask

    task automatic drv_wr1(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.wr1_en = 1'b1; bus.wr1_addr = a; bus.wr1_data = d;
    endtask

    task automatic drv_iss(input logic [AW-1:0] a);
        bus.iss_en = 1'b1; bus.iss_addr = a;
    endtask

    // Tests
    task automatic test_reset();
        for (int a = 0; a < 32; a++) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'(31 - a));
            #1;
            n_cmp++; if (bus.rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_data0 a=%0d got %h exp 0", a, bus.rd_data[31:0]); end
            n_cmp++; if (bus.rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL reset_data1 a=%0d got %h exp 0", 31 - a, bus.rd_data[63:32]); end
            n_cmp++; if (bus.rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy a=%0d got %b exp 00", a, bus.rd_busy); end
        end
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_pend_cnt got %0d exp 0", bus.pend_cnt); end
    endtask

    task automatic test_write_bypass();
        idle();
        drv_wr0(5, 32'hDEADBEEF); set_rd(0, 5);
        drv_wr1(6, 32'h600DF00D); set_rd(1, 6);
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_wr0 got %h exp deadbeef", bus.rd_data[31:0]); end
        n_cmp++; if (bus.rd_data[63:32] !== 32'h600DF00D) begin n_fail++; $display("FAIL bypass_wr1 got %h exp 600df00d", bus.rd_data[63:32]); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL array_x5 got %h exp deadbeef", bus.rd_data[31:0]); end
        n_cmp++; if (bus.rd_data[63:32] !== 32'h600DF00D) begin n_fail++; $display("FAIL array_x6 got %h exp 600df00d", bus.rd_data[63:32]); end
    endtask

    task automatic test_zero_reg();
        idle();
        drv_wr0(REG_ZERO, 32'h1234); drv_iss(REG_ZERO); set_rd(0, REG_ZERO);
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_bypass got %h exp 0", bus.rd_data[31:0]); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_array got %h exp 0", bus.rd_data[31:0]); end
        n_cmp++; if (bus.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got %b exp 0", bus.rd_busy[0]); end
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_fail++; $display("FAIL x0_pend_cnt got %0d exp 0", bus.pend_cnt); end
    endtask

    task automatic test_collision();
        idle();
        drv_wr0(7, 32'hAAAA); drv_wr1(7, 32'h5555); set_rd(1, 7);
        #1;
        n_cmp++; if (bus.rd_data[63:32] !== 32'hAAAA) begin n_fail++; $display("FAIL collide_bypass got %h exp aaaa", bus.rd_data[63:32]); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd_data[63:32] !== 32'hAAAA) begin n_fail++; $display("FAIL collide_array got %h exp aaaa", bus.rd_data[63:32]); end
    endtask

    task automatic test_scoreboard();
        idle();
        drv_iss(3); set_rd(0, 3);
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL iss_same_cycle_busy got %b exp 0", bus.rd_busy[0]); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL iss_busy got %b exp 1", bus.rd_busy[0]); end
        n_cmp++; if (bus.pend_cnt !== 6'd1) begin n_fail++; $display("FAIL iss_pend_cnt got %0d exp 1", bus.pend_cnt); end
        // Re-issue plus writeback on the same register: newer producer keeps it pending.
        drv_iss(3); drv_wr1(3, 32'h33);
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL iss_wb_hit_busy got %b exp 0", bus.rd_busy[0]); end
        n_cmp++; if (bus.rd_data[31:0] !== 32'h33) begin n_fail++; $display("FAIL iss_wb_bypass got %h exp 33", bus.rd_data[31:0]); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL iss_wb_busy got %b exp 1", bus.rd_busy[0]); end
        n_cmp++; if (bus.pend_cnt !== 6'd1) begin n_fail++; $display("FAIL iss_wb_pend_cnt got %0d exp 1", bus.pend_cnt); end
        drv_wr1(3, 32'h44);
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL wb_drop_busy got %b exp 0", bus.rd_busy[0]); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_fail++; $display("FAIL wb_pend_cnt got %0d exp 0", bus.pend_cnt); end
        n_cmp++; if (bus.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL wb_busy got %b exp 0", bus.rd_busy[0]); end
        n_cmp++; if (bus.rd_data[31:0] !== 32'h44) begin n_fail++; $display("FAIL wb_data got %h exp 44", bus.rd_data[31:0]); end
        // Two pending registers, duplicate issue, then both cleared in one cycle.
        drv_iss(11); tick(); idle();
        drv_iss(12); tick(); idle();
        drv_iss(11); tick(); idle();
        #1;
        n_cmp++; if (bus.pend_cnt !== 6'd2) begin n_fail++; $display("FAIL dup_iss_pend_cnt got %0d exp 2", bus.pend_cnt); end
        drv_wr0(11, 32'hB); drv_wr1(12, 32'hC);
        tick(); idle();
        #1;
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_fail++; $display("FAIL dual_clr_pend_cnt got %0d exp 0", bus.pend_cnt); end
        // Writeback to a register that is not pending must not decrement.
        drv_wr0(20, 32'h20);
        tick(); idle();
        #1;
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_fail++; $display("FAIL idle_wb_pend_cnt got %0d exp 0", bus.pend_cnt); end
    endtask

    task automatic test_flush_reset();
        idle();
        drv_iss(1); tick(); idle();
        drv_iss(2); tick(); idle();
        drv_iss(4); tick(); idle();
        set_rd(0, 1); set_rd(1, 2);
        #1;
        n_cmp++; if (bus.pend_cnt !== 6'd3) begin n_fail++; $display("FAIL three_pend_cnt got %0d exp 3", bus.pend_cnt); end
        n_cmp++; if (bus.rd_busy !== 2'b11) begin n_fail++; $display("FAIL three_busy got %b exp 11", bus.rd_busy); end
        bus.flush = 1'b1; drv_iss(9);
        tick(); idle();
        set_rd(0, 9);
        #1;
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_fail++; $display("FAIL flush_pend_cnt got %0d exp 0", bus.pend_cnt); end
        n_cmp++; if (bus.rd_busy !== 2'b00) begin n_fail++; $display("FAIL flush_busy got %b exp 00", bus.rd_busy); end
        drv_iss(5); drv_wr0(8, 32'h88);
        tick(); idle();
        set_rd(0, 8); set_rd(1, 5);
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h88) begin n_fail++; $display("FAIL pre_rst_data got %h exp 88", bus.rd_data[31:0]); end
        n_cmp++; if (bus.rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL pre_rst_busy got %b exp 1", bus.rd_busy[1]); end
        // Assert reset between edges; state must clear without a clock edge.
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL async_rst_x8 got %h exp 0", bus.rd_data[31:0]); end
        n_cmp++; if (bus.rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL async_rst_x5 got %h exp 0", bus.rd_data[63:32]); end
        n_cmp++; if (bus.rd_busy !== 2'b00) begin n_fail++; $display("FAIL async_rst_busy got %b exp 00", bus.rd_busy); end
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_fail++; $display("FAIL async_rst_pend_cnt got %0d exp 0", bus.pend_cnt); end
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] d;
        logic [XLEN-1:0] exp;
        idle();
        for (int i = 1; i <= 4; i++) begin
            d = 32'h1111_0000 * XLEN'(i) + XLEN'(i);
            drv_wr0(AW'(i), d);
            exp_q.push_back(d);
            tick();
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            set_rd(1, AW'(i));
            #1;
            exp = exp_q.pop_front();
            n_cmp++; if (bus.rd_data[63:32] !== exp) begin n_fail++; $display("FAIL b2b_x%0d got %h exp %h", i, bus.rd_data[63:32], exp); end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        bus.rd_addr = '0;
        idle();
        #12 reset = 1'b1;
        test_reset();
        tick();
        test_write_bypass();
        tick();
        test_zero_reg();
        tick();
        test_collision();
        tick();
        test_scoreboard();
        tick();
        test_flush_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
